// File: rtl/decoder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : Decoder_4To2bits
// Purpose  : Fixed 4-to-2 combinational code decoder.
// Ports    : A, B, C, D - code bits (A is the MSB)
//            Y1, Y0     - decoded result bits
// Revision : 1.0 - initial release
// ============================================================================
module Decoder_4To2bits (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic Y1,
    output logic Y0
);

    assign Y1 = ~(B ^ D);
    assign Y0 = (~A &  B & ~C)      | (~A & ~C &  D)      |
                ( A &  B &  C)      | ( A &  C &  D)      |
                (~A & ~B &  C & ~D) | ( A & ~B & ~C & ~D);

endmodule

// ============================================================================
// Module   : decoder_share_arbiter
// Purpose  : Round-robin arbiter/sequencer that time-shares one
//            Decoder_4To2bits among NREQ requesters. One code is accepted in
//            IDLE, decoded in EVAL, and held in RESP until the consumer takes
//            it. The result is tagged with the requester index.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            req_valid/req_ready  - per-requester handshake (ready one-hot)
//            req_data             - 4-bit code per requester {A,B,C,D}
//            rsp_valid/rsp_ready  - result handshake
//            rsp_id, rsp_data     - requester index and {Y1,Y0}
//            busy                 - high outside IDLE
//            op_count             - completed responses, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module decoder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [1:0]          rsp_data,
    output logic                busy,
    output logic [15:0]         op_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EVAL = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_nextState;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [3:0]     r_opData;
    logic [1:0]     r_rspData;
    logic           r_rspValid;
    logic [15:0]    r_opCount;

    // Round-robin search split in two halves: requesters at or above the
    // pointer win first; otherwise the lowest valid index below it wins.
    logic           w_hiFound;
    logic           w_loFound;
    logic [IDW-1:0] w_hiIdx;
    logic [IDW-1:0] w_loIdx;
    logic [3:0]     w_hiCode;
    logic [3:0]     w_loCode;
    logic           w_found;
    logic [IDW-1:0] w_grantIdx;
    logic [3:0]     w_grantCode;
    logic [IDW-1:0] w_nextPtr;
    logic           w_accept;
    logic           w_rspDone;
    logic           w_y1;
    logic           w_y0;

    always_comb begin
        w_hiFound = 1'b0;
        w_loFound = 1'b0;
        w_hiIdx   = '0;
        w_loIdx   = '0;
        w_hiCode  = '0;
        w_loCode  = '0;
        // Descending scan leaves the lowest matching index in each half.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i >= int'(r_ptr)) begin
                    w_hiFound = 1'b1;
                    w_hiIdx   = IDW'(i);
                    w_hiCode  = req_data[4*i +: 4];
                end else begin
                    w_loFound = 1'b1;
                    w_loIdx   = IDW'(i);
                    w_loCode  = req_data[4*i +: 4];
                end
            end
        end
    end

    assign w_found     = w_hiFound | w_loFound;
    assign w_grantIdx  = w_hiFound ? w_hiIdx  : w_loIdx;
    assign w_grantCode = w_hiFound ? w_hiCode : w_loCode;
    assign w_nextPtr   = (w_grantIdx == IDW'(NREQ - 1)) ? '0 : w_grantIdx + IDW'(1);
    assign w_accept    = (r_state == c_IDLE) && w_found;
    assign w_rspDone   = (r_state == c_RESP) && r_rspValid && rsp_ready;

    Decoder_4To2bits u_decoder (
        .A  (r_opData[3]),
        .B  (r_opData[2]),
        .C  (r_opData[1]),
        .D  (r_opData[0]),
        .Y1 (w_y1),
        .Y0 (w_y0)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)  w_nextState = c_EVAL;
            c_EVAL:                 w_nextState = c_RESP;
            c_RESP:  if (w_rspDone) w_nextState = c_IDLE;
            default:                w_nextState = c_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grantIdx] = 1'b1;
        end
        busy = (r_state != c_IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_id       <= '0;
            r_opData   <= '0;
            r_rspData  <= '0;
            r_rspValid <= 1'b0;
            r_opCount  <= '0;
        end else begin
            if (w_accept) begin
                r_opData <= w_grantCode;
                r_id     <= w_grantIdx;
                r_ptr    <= w_nextPtr;
            end
            if (r_state == c_EVAL) begin
                r_rspData  <= {w_y1, w_y0};
                r_rspValid <= 1'b1;
            end
            if (w_rspDone) begin
                r_rspValid <= 1'b0;
                r_opCount  <= r_opCount + 16'd1;
            end
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_rspData;
    assign op_count  = r_opCount;

endmodule
`default_nettype wire

// File: tb/tb_decoder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_share_arbiter
// Purpose  : Directed self-checking bench for decoder_share_arbiter:
//            reset state, single op, truth-table sweep, round-robin order,
//            backpressure, mid-operation reset and op_count wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [1:0]          rsp_data;
    logic                busy;
    logic [15:0]         op_count;

    int nCmp = 0;
    int nErr = 0;

    // Hand-evaluated {Y1,Y0} for codes 0000 .. 1111
    logic [1:0] truth [16] = '{2'b10, 2'b01, 2'b11, 2'b00,
                               2'b01, 2'b11, 2'b00, 2'b10,
                               2'b11, 2'b00, 2'b10, 2'b01,
                               2'b00, 2'b10, 2'b01, 2'b11};

    decoder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendOne(input int id, input logic [3:0] code);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_data[4*id +: 4] = code;
    endtask

    // One full op with only requester id valid and rsp_ready high.
    task automatic runSingle(input int id, input logic [3:0] code,
                             input logic [1:0] exp, input logic [15:0] cntBefore);
        logic [15:0] cntAfter;
        cntAfter = cntBefore + 16'd1;
        sendOne(id, code);
        #1 check("grant", 32'(req_ready), 32'(1) << id);
        tick();                                   // EVAL
        req_valid = '0;
        check("evalBusy", 32'(busy), 32'd1);
        check("evalValid", 32'(rsp_valid), 32'd0);
        tick();                                   // RESP
        check("rspValid", 32'(rsp_valid), 32'd1);
        check("rspData", 32'(rsp_data), 32'(exp));
        check("rspId", 32'(rsp_id), 32'(id));
        tick();                                   // back to IDLE
        check("idleValid", 32'(rsp_valid), 32'd0);
        check("opCount", 32'(op_count), 32'(cntAfter));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rstValid", 32'(rsp_valid), 32'd0);
        check("rstId", 32'(rsp_id), 32'd0);
        check("rstData", 32'(rsp_data), 32'd0);
        check("rstBusy", 32'(busy), 32'd0);
        check("rstCount", 32'(op_count), 32'd0);
        check("rstReady", 32'(req_ready), 32'd0);

        // Single request: requester 0, 0101 -> 11
        runSingle(0, 4'b0101, 2'b11, 16'd0);

        // Truth-table sweep through requester 2
        for (int c = 0; c < 16; c++) begin
            runSingle(2, 4'(c), truth[c], 16'(c + 1));
        end

        // Round robin from reset with all requesters valid
        rst = 1'b1;
        req_valid = 4'b1111;
        req_data = 16'h3210;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("rrGrant", 32'(req_ready), 32'(1) << (k % 4));
            tick();                               // EVAL
            check("rrEvalReady", 32'(req_ready), 32'd0);
            check("rrEvalBusy", 32'(busy), 32'd1);
            tick();                               // RESP
            check("rrRespReady", 32'(req_ready), 32'd0);
            check("rrId", 32'(rsp_id), 32'(k % 4));
            check("rrData", 32'(rsp_data), 32'(truth[k % 4]));
            tick();                               // IDLE
        end
        req_valid = '0;
        check("rrCount", 32'(op_count), 32'd5);

        // Backpressure: requester 3, 1011 -> 01, pointer now at 1
        rsp_ready = 1'b0;
        sendOne(3, 4'b1011);
        #1 check("bpGrant", 32'(req_ready), 32'b1000);
        tick();                                   // EVAL
        req_valid = 4'b1111;
        tick();                                   // RESP
        for (int k = 0; k < 5; k++) begin
            check("bpValid", 32'(rsp_valid), 32'd1);
            check("bpData", 32'(rsp_data), 32'b01);
            check("bpId", 32'(rsp_id), 32'd3);
            check("bpReady", 32'(req_ready), 32'd0);
            check("bpBusy", 32'(busy), 32'd1);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        check("bpRelValid", 32'(rsp_valid), 32'd0);
        check("bpRelBusy", 32'(busy), 32'd0);
        check("bpRelCount", 32'(op_count), 32'd6);

        // Reset while in EVAL
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reCount0", 32'(op_count), 32'd0);
        sendOne(1, 4'b0100);
        #1 check("reGrant", 32'(req_ready), 32'b0010);
        tick();                                   // EVAL
        check("reBusy", 32'(busy), 32'd1);
        req_valid = '0;
        rst = 1'b1;
        tick();
        check("reValid", 32'(rsp_valid), 32'd0);
        check("reBusyClr", 32'(busy), 32'd0);
        check("reCount", 32'(op_count), 32'd0);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1 check("rePtr", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        // Reset while in RESP
        rsp_ready = 1'b0;
        sendOne(2, 4'b1111);
        #1 check("rrsGrant", 32'(req_ready), 32'b0100);
        tick();                                   // EVAL
        req_valid = '0;
        tick();                                   // RESP
        check("rrsValid1", 32'(rsp_valid), 32'd1);
        check("rrsData1", 32'(rsp_data), 32'b11);
        rst = 1'b1;
        tick();
        check("rrsValid", 32'(rsp_valid), 32'd0);
        check("rrsBusy", 32'(busy), 32'd0);
        check("rrsCount", 32'(op_count), 32'd0);
        check("rrsId", 32'(rsp_id), 32'd0);
        check("rrsData", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1 check("rrsPtr", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        // op_count wrap
        force dut.r_opCount = 16'hFFFE;
        tick();
        release dut.r_opCount;
        check("wrapPre", 32'(op_count), 32'hFFFE);
        runSingle(0, 4'b0000, 2'b10, 16'hFFFE);
        runSingle(1, 4'b0001, 2'b01, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
